kb_info_writer: RTL

Keyboard-side producer for the `kb_info` register window. The block receives PS/2 device-to-host frames, validates them, and folds `E0`/`F0` prefixes into single key events. It tracks Shift/Ctrl state and emits one 32-bit event word per key event on the `kb_wraddr`/`kb_wrdata`/`kb_we` write port of `memory_map`. The CPU polls that word at `KB_INFO_OFFSET`.

---
 rtl/kb_info_writer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/kb_info_writer.sv
// PS/2 keyboard receiver that folds E0/F0 prefixes into single key events and
// publishes one 32-bit event word per key on the kb_info write port.
module kb_info_writer #(
  parameter logic [31:0] KB_INFO_OFFSET = 32'h00500000,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [15:0] SEQ_INIT       = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] kb_wraddr,
  output logic [31:0] kb_wrdata,
  output logic        kb_we,
  output logic        frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t          state, state_n;
  logic            ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic            ps2_dat_p0, ps2_dat_p1;
  logic            fall, dat;
  logic [3:0]      bit_cnt;
  logic [10:0]     frame;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            start_en, shift_en, check_en, to_expire;
  logic            ext_f, brk_f;
  logic            shift_l, shift_r, ctrl;
  logic            shift_l_n, shift_r_n, ctrl_n;
  logic [15:0]     seq;
  logic [7:0]      code;
  logic            frame_ok, is_event;

  function automatic logic frame_valid(input logic [10:0] f);
    // f[0]=start, f[8:1]=data, f[9]=parity, f[10]=stop
    return (^f[9:1]) & f[10];
  endfunction

  function automatic logic [31:0] pack_event(
    input logic [7:0]  sc,
    input logic        ext,
    input logic        brk,
    input logic        shift,
    input logic        ctl,
    input logic [15:0] sq
  );
    return {sq, 4'b0000, ctl, shift, brk, ext, sc};
  endfunction

  assign kb_wraddr = KB_INFO_OFFSET;

  // ---- stage p0/p1: two-flop synchronizers; p2: clock history for edge detect
  // Reset to the idle-high line level so release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_p0 <= 1'b1;
      ps2_clk_p1 <= 1'b1;
      ps2_clk_p2 <= 1'b1;
      ps2_dat_p0 <= 1'b1;
      ps2_dat_p1 <= 1'b1;
    end else begin
      ps2_clk_p0 <= ps2_clk;
      ps2_clk_p1 <= ps2_clk_p0;
      ps2_clk_p2 <= ps2_clk_p1;
      ps2_dat_p0 <= ps2_data;
      ps2_dat_p1 <= ps2_dat_p0;
    end
  end

  assign fall = ps2_clk_p2 & ~ps2_clk_p1;
  assign dat  = ps2_dat_p1;

  // ---- frame FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  assign to_hit = (to_cnt == TO_MAX);

  // ---- frame FSM: next state
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (fall && !dat) state_n = S_RECV;
      end
      S_RECV: begin
        if (fall && bit_cnt == 4'd10) state_n = S_CHECK;
        else if (!fall && to_hit)     state_n = S_IDLE;
      end
      S_CHECK: begin
        // An edge here is the start bit of the next frame and must be kept.
        if (fall && !dat) state_n = S_RECV;
        else              state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ---- frame FSM: control outputs
  always_comb begin
    start_en  = 1'b0;
    shift_en  = 1'b0;
    check_en  = 1'b0;
    to_expire = 1'b0;
    case (state)
      S_IDLE: begin
        start_en = fall & ~dat;
        shift_en = fall & ~dat;
      end
      S_RECV: begin
        shift_en  = fall;
        to_expire = ~fall & to_hit;
      end
      S_CHECK: begin
        check_en = 1'b1;
        start_en = fall & ~dat;
        shift_en = fall & ~dat;
      end
      default: ;
    endcase
  end

  // bit_cnt holds the number of bits already captured in the current frame
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 4'd0;
    end else if (start_en) begin
      bit_cnt <= 4'd1;
    end else if (state == S_RECV && fall) begin
      bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
    end else if (to_expire) begin
      bit_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) frame <= {dat, frame[10:1]};
  end

  always_ff @(posedge clk) begin
    if (rst)                          to_cnt <= '0;
    else if (fall || state != S_RECV) to_cnt <= '0;
    else                              to_cnt <= to_cnt + 1'b1;
  end

  // ---- check stage: decode the completed frame
  assign code     = frame[8:1];
  assign frame_ok = frame_valid(frame);
  assign is_event = check_en & frame_ok & (code != 8'hE0) & (code != 8'hF0);

  always_comb begin
    shift_l_n = shift_l;
    shift_r_n = shift_r;
    ctrl_n    = ctrl;
    if (code == 8'h12 && !ext_f) shift_l_n = ~brk_f;
    if (code == 8'h59 && !ext_f) shift_r_n = ~brk_f;
    if (code == 8'h14)           ctrl_n    = ~brk_f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_f   <= 1'b0;
      brk_f   <= 1'b0;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
      ctrl    <= 1'b0;
      seq     <= SEQ_INIT;
    end else if (to_expire || (check_en && !frame_ok)) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (check_en) begin
      if (code == 8'hE0) begin
        ext_f <= 1'b1;
      end else if (code == 8'hF0) begin
        brk_f <= 1'b1;
      end else begin
        shift_l <= shift_l_n;
        shift_r <= shift_r_n;
        ctrl    <= ctrl_n;
        ext_f   <= 1'b0;
        brk_f   <= 1'b0;
        seq     <= seq + 16'd1;
      end
    end
  end

  // ---- output stage: registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      kb_we     <= 1'b0;
      frame_err <= 1'b0;
      kb_wrdata <= 32'd0;
    end else begin
      kb_we     <= is_event;
      frame_err <= (check_en & ~frame_ok) | to_expire;
      if (is_event)
        kb_wrdata <= pack_event(code, ext_f, brk_f, shift_l_n | shift_r_n,
                                ctrl_n, seq + 16'd1);
    end
  end

endmodule
